alu_share_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU (AND/OR/ADD/SUB/SLT, 6-bit function code) between two requesters, e.g. the EX-stage datapath and an address/branch-compare unit.
- Round-robin arbitration, valid/ready request handshake, registered operands driven to the ALU.
- Registered result returned to the winning requester, with per-requester response backpressure and an illegal-function flag.

---
 rtl/alu_ctrl_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 28 ++
 rtl/alu_share_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing arbiter: function codes, FSM states, legality check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package alu_ctrl_pkg;

    localparam int          SIG_W_PKG = 6;

    localparam logic [5:0]  ALU_AND = 6'b100100;  // 36
    localparam logic [5:0]  ALU_OR  = 6'b100101;  // 37
    localparam logic [5:0]  ALU_ADD = 6'b100000;  // 32
    localparam logic [5:0]  ALU_SUB = 6'b100010;  // 34
    localparam logic [5:0]  ALU_SLT = 6'b101010;  // 42

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no operation held
        EXEC = 2'd1,   // operands registered, ALU evaluating
        RESP = 2'd2    // result held for the owning requester
    } state_t;

    function automatic logic legal_sig(input logic [SIG_W_PKG-1:0] code);
        return (code == ALU_AND) || (code == ALU_OR)  || (code == ALU_ADD) ||
               (code == ALU_SUB) || (code == ALU_SLT);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the requester that did not win last time wins a tie.
// Latency: purely combinational; the pointer is kept by the parent.
// Backpressure: no grant is produced while en is low.
//
// Ports: valid[1:0] requests, last = id of the previous winner, en = accept window,
//        grant_onehot[1:0] qualified grant, grant_id = chosen id (meaningful when a grant is raised).
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant_onehot,
    output logic       grant_id
);

    always_comb begin
        grant_id     = 1'b0;
        grant_onehot = 2'b00;
        if (valid == 2'b11) begin
            grant_id = ~last;
        end else if (valid[1]) begin
            grant_id = 1'b1;
        end
        if (en && (valid != 2'b00)) begin
            grant_onehot = grant_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Latency: accept edge -> operands on alu_* -> next edge registers result and raises rspN_valid.
// Backpressure: a held result blocks new accepts until its owner asserts rspN_ready.
//
// Ports: reqN_valid/ready/a/b/signal request handshake per requester; rspN_valid/ready response
//        handshake per requester sharing rsp_data/rsp_err; alu_dataA/B/signal registered ALU
//        inputs, alu_dataOut ALU result; busy high whenever an operation is in flight or held.
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SIG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SIG_W-1:0] req0_signal,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SIG_W-1:0] req1_signal,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_dataA,
    output logic [WIDTH-1:0] alu_dataB,
    output logic [SIG_W-1:0] alu_signal,
    input  logic [WIDTH-1:0] alu_dataOut,
    output logic             busy
);

    state_t state;
    logic   last;     // previous winner; reset to 1 so requester 0 wins the first tie
    logic   id;       // owner of the in-flight / held operation
    logic   err_r;    // illegal-code flag travelling alongside the operands

    logic       held_hs;
    logic       acc;
    logic [1:0] grant;
    logic       win_id;
    logic       accept;

    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [SIG_W-1:0] win_sig;

    // A new request can be taken in the same cycle the held result is collected,
    // which is what gives one operation every two cycles under no backpressure.
    assign held_hs = (state == RESP) && (id ? rsp1_ready : rsp0_ready);
    assign acc     = (state == IDLE) || held_hs;

    rr_arb2 u_arb (
        .valid        ({req1_valid, req0_valid}),
        .last         (last),
        .en           (acc),
        .grant_onehot (grant),
        .grant_id     (win_id)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;

    assign win_a   = win_id ? req1_a      : req0_a;
    assign win_b   = win_id ? req1_b      : req0_b;
    assign win_sig = win_id ? req1_signal : req0_signal;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last       <= 1'b1;
            id         <= 1'b0;
            err_r      <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            alu_dataA  <= '0;
            alu_dataB  <= '0;
            alu_signal <= '0;
        end else begin
            case (state)
                EXEC: begin
                    rsp_data   <= alu_dataOut;
                    rsp_err    <= err_r;
                    rsp0_valid <= ~id;
                    rsp1_valid <= id;
                    state      <= RESP;
                end
                RESP: begin
                    if (held_hs) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    if (accept) begin
                        state <= EXEC;
                    end
                end
            endcase

            // Operand capture; alu_* otherwise hold their last value.
            if (accept) begin
                alu_dataA  <= win_a;
                alu_dataB  <= win_b;
                alu_signal <= win_sig;
                id         <= win_id;
                last       <= win_id;
                err_r      <= ~legal_sig(win_sig);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam logic [5:0] S_AND = 6'd36;
    localparam logic [5:0] S_OR  = 6'd37;
    localparam logic [5:0] S_ADD = 6'd32;
    localparam logic [5:0] S_SUB = 6'd34;
    localparam logic [5:0] S_SLT = 6'd42;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [5:0]  req0_signal, req1_signal;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] alu_dataA, alu_dataB, alu_dataOut;
    logic [5:0]  alu_signal;
    logic        busy;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t exp0[$];
    exp_t exp1[$];
    int   grant_log[$];
    int   acc_cyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_arbiter dut (
        .clk (clk), .reset (reset),
        .req0_valid (req0_valid), .req0_ready (req0_ready),
        .req0_a (req0_a), .req0_b (req0_b), .req0_signal (req0_signal),
        .req1_valid (req1_valid), .req1_ready (req1_ready),
        .req1_a (req1_a), .req1_b (req1_b), .req1_signal (req1_signal),
        .rsp0_valid (rsp0_valid), .rsp1_valid (rsp1_valid),
        .rsp0_ready (rsp0_ready), .rsp1_ready (rsp1_ready),
        .rsp_data (rsp_data), .rsp_err (rsp_err),
        .alu_dataA (alu_dataA), .alu_dataB (alu_dataB), .alu_signal (alu_signal),
        .alu_dataOut (alu_dataOut), .busy (busy)
    );

    // Reference ALU attached to the shared port; unknown codes yield zero.
    always_comb begin
        case (alu_signal)
            S_AND:   alu_dataOut = alu_dataA & alu_dataB;
            S_OR:    alu_dataOut = alu_dataA | alu_dataB;
            S_ADD:   alu_dataOut = alu_dataA + alu_dataB;
            S_SUB:   alu_dataOut = alu_dataA - alu_dataB;
            S_SLT:   alu_dataOut = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
            default: alu_dataOut = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the expected response for whichever requester completes a handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp0_valid || rsp1_valid)
                chk("rsp_onehot", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
            if (rsp0_valid && rsp0_ready) begin
                if (exp0.size() == 0) begin
                    chk("rsp0_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp0.pop_front();
                    chk("rsp0_data", rsp_data, e.d);
                    chk("rsp0_err", {31'd0, rsp_err}, {31'd0, e.e});
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp1.size() == 0) begin
                    chk("rsp1_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp1.pop_front();
                    chk("rsp1_data", rsp_data, e.d);
                    chk("rsp1_err", {31'd0, rsp_err}, {31'd0, e.e});
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] sig, input logic [31:0] ed, input logic ee,
                         input bit expect_rsp);
        int n;
        bit got;
        exp_t e;
        n = 0;
        got = 0;
        e.d = ed;
        e.e = ee;
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_signal = sig; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_signal = sig; req1_valid = 1'b1;
        end
        while (!got && n < 50) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) begin
                got = 1;
                if (expect_rsp) begin
                    if (id == 0) exp0.push_back(e);
                    else         exp1.push_back(e);
                end
                grant_log.push_back(id);
                acc_cyc.push_back(cyc);
            end
            n++;
        end
        if (!got) chk("issue_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic wait_valid(input int id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((id == 0) ? rsp0_valid : rsp1_valid) && n < 20);
        chk("wait_valid", {31'd0, (id == 0) ? rsp0_valid : rsp1_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk("drain_q0", exp0.size(), 32'd0);
        chk("drain_q1", exp1.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_signal = 0;
        req1_a = 0; req1_b = 0; req1_signal = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_alu_dataA", alu_dataA, 32'd0);
        chk("rst_alu_signal", {26'd0, alu_signal}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single ADD with cycle-by-cycle latency checks.
        rsp0_ready = 1'b1;
        req0_a = 5; req0_b = 7; req0_signal = S_ADD; req0_valid = 1'b1;
        @(negedge clk);
        chk("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
        exp0.push_back('{32'd12, 1'b0});
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_alu_dataA", alu_dataA, 32'd5);
        chk("t1_busy_exec", {31'd0, busy}, 32'd1);
        chk("t1_no_rsp_yet", {31'd0, rsp0_valid}, 32'd0);
        @(negedge clk);
        chk("t1_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        @(negedge clk);
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        drain();

        // Both requesters continuously valid: alternating grants, one op per 2 cycles.
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        grant_log.delete();
        acc_cyc.delete();
        fork
            begin
                issue(0, 32'd10, 32'd3, S_SUB, 32'd7, 1'b0, 1);
                issue(0, 32'd1, 32'd1, S_ADD, 32'd2, 1'b0, 1);
            end
            begin
                issue(1, 32'd2, 32'd9, S_SLT, 32'd1, 1'b0, 1);
                issue(1, 32'hF0, 32'h3C, S_AND, 32'h30, 1'b0, 1);
            end
        join
        chk("rr_count", grant_log.size(), 32'd4);
        if (grant_log.size() == 4) begin
            chk("rr_g0", grant_log[0], 32'd0);
            chk("rr_g1", grant_log[1], 32'd1);
            chk("rr_g2", grant_log[2], 32'd0);
            chk("rr_g3", grant_log[3], 32'd1);
            for (int i = 1; i < 4; i++)
                chk("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd2);
        end
        drain();

        // Backpressure on requester 1 while requester 0 waits.
        rsp1_ready = 1'b0;
        issue(1, 32'hF0, 32'h0F, S_OR, 32'hFF, 1'b0, 1);
        wait_valid(1);
        fork
            issue(0, 32'd3, 32'd4, S_ADD, 32'd7, 1'b0, 1);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
                    chk("bp_rsp_data", rsp_data, 32'hFF);
                    chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                rsp1_ready = 1'b1;
                @(negedge clk);
                chk("bp_accept_on_release", {31'd0, req0_ready}, 32'd1);
            end
        join
        drain();

        // Illegal function code, then a legal one.
        issue(0, 32'd1, 32'd2, 6'b000111, 32'd0, 1'b1, 1);
        issue(0, 32'd9, 32'd4, S_SUB, 32'd5, 1'b0, 1);
        drain();

        // Asynchronous reset while in EXEC.
        issue(0, 32'd8, 32'd8, S_ADD, 32'd16, 1'b0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_alu_dataA", alu_dataA, 32'd0);
        chk("mid_rst_alu_signal", {26'd0, alu_signal}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        grant_log.delete();
        fork
            issue(0, 32'd6, 32'd6, S_ADD, 32'd12, 1'b0, 1);
            issue(1, 32'd5, 32'd3, S_SUB, 32'd2, 1'b0, 1);
        join
        chk("post_rst_first_grant", grant_log[0], 32'd0);
        drain();

        // rsp1_ready while requester 0 owns the held result is ignored.
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        issue(0, 32'hAA, 32'h55, S_OR, 32'hFF, 1'b0, 1);
        wait_valid(0);
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("ign_rsp0_valid_pulse", {31'd0, rsp0_valid}, 32'd1);
        @(posedge clk);
        #1;
        rsp1_ready = 1'b0;
        @(negedge clk);
        chk("ign_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("ign_busy", {31'd0, busy}, 32'd1);
        chk("ign_rsp_data", rsp_data, 32'hFF);
        chk("ign_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        @(posedge clk);
        #1;
        rsp0_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
